memory_responder: RTL and testbench

//  Responder side of the cache/request-unit memory handshake. Arbitrates the instruction-fetch

---
 rtl/memory_responder.sv | 170 +++++++++++++++++
 tb/tb_memory_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : memory_responder
// Description : Arbitrates instruction and data requests onto one wait-state
//               RAM port and answers each with a single-cycle hit pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_responder #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic [1:0]        ram_state,
    output logic              bus_err,
    input  logic              err_clr
);

    localparam logic [1:0]  c_RAM_ACCESS = 2'b10;
    localparam logic [1:0]  c_RAM_ERROR  = 2'b11;
    localparam logic [15:0] c_CNT_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        D_REQ = 3'd1,
        I_REQ = 3'd2,
        D_RSP = 3'd3,
        I_RSP = 3'd4
    } state_t;

    state_t              r_state;
    logic [15:0]         r_cnt;
    logic                r_last_d;
    logic                r_wr;
    logic [DATA_W-1:0]   r_data;
    logic                r_ihit;
    logic [DATA_W-1:0]   r_iload;
    logic                r_dhit;
    logic [DATA_W-1:0]   r_dload;
    logic                r_ram_ren;
    logic                r_ram_wen;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_store;
    logic                r_bus_err;

    logic w_dpend;
    logic w_serve_d;
    logic w_serve_i;
    logic w_in_req;
    logic w_access;
    logic w_abort;

    // Round-robin only matters when both ports compete; last_d picks the loser of last time.
    assign w_dpend   = dREN | dWEN;
    assign w_serve_d = w_dpend & (~iREN | ~r_last_d);
    assign w_serve_i = iREN & ~w_serve_d;

    assign w_in_req  = (r_state == D_REQ) || (r_state == I_REQ);
    assign w_access  = (ram_state == c_RAM_ACCESS);
    assign w_abort   = w_in_req && !w_access &&
                       ((ram_state == c_RAM_ERROR) || (r_cnt == c_CNT_LAST));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last_d    <= 1'b0;
            r_wr        <= 1'b0;
            r_data      <= '0;
            r_ihit      <= 1'b0;
            r_iload     <= '0;
            r_dhit      <= 1'b0;
            r_dload     <= '0;
            r_ram_ren   <= 1'b0;
            r_ram_wen   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_store <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ihit  <= 1'b0;
                    r_dhit  <= 1'b0;
                    r_iload <= '0;
                    r_dload <= '0;
                    // While a hit is still visible the requester has not yet dropped its level.
                    if (!(r_ihit || r_dhit)) begin
                        if (w_serve_d) begin
                            r_state     <= D_REQ;
                            r_wr        <= dWEN;
                            r_ram_ren   <= ~dWEN;
                            r_ram_wen   <= dWEN;
                            r_ram_addr  <= daddr;
                            r_ram_store <= dWEN ? dstore : '0;
                        end else if (w_serve_i) begin
                            r_state     <= I_REQ;
                            r_wr        <= 1'b0;
                            r_ram_ren   <= 1'b1;
                            r_ram_wen   <= 1'b0;
                            r_ram_addr  <= iaddr;
                            r_ram_store <= '0;
                        end
                    end
                end
                D_REQ, I_REQ: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_access || w_abort) begin
                        r_data      <= w_access ? ram_load : '0;
                        r_ram_ren   <= 1'b0;
                        r_ram_wen   <= 1'b0;
                        r_ram_addr  <= '0;
                        r_ram_store <= '0;
                        r_state     <= (r_state == D_REQ) ? D_RSP : I_RSP;
                    end
                end
                D_RSP: begin
                    r_dhit   <= 1'b1;
                    r_dload  <= r_wr ? '0 : r_data;
                    r_last_d <= 1'b1;
                    r_cnt    <= '0;
                    r_state  <= IDLE;
                end
                I_RSP: begin
                    r_ihit   <= 1'b1;
                    r_iload  <= r_data;
                    r_last_d <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_abort) begin
                r_bus_err <= 1'b1;
            end else if (err_clr) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    assign ihit      = r_ihit;
    assign iload     = r_iload;
    assign dhit      = r_dhit;
    assign dload     = r_dload;
    assign ram_ren   = r_ram_ren;
    assign ram_wen   = r_ram_wen;
    assign ram_addr  = r_ram_addr;
    assign ram_store = r_ram_store;
    assign bus_err   = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_responder
// Description : Directed self-checking bench for memory_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_responder;

    localparam logic [1:0] c_FREE   = 2'b00;
    localparam logic [1:0] c_BUSY   = 2'b01;
    localparam logic [1:0] c_ACCESS = 2'b10;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic [1:0]  ram_state;
    logic        bus_err;
    logic        err_clr;

    int tests  = 0;
    int failed = 0;

    memory_responder #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .ihit     (ihit),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dhit     (dhit),
        .dload    (dload),
        .ram_ren  (ram_ren),
        .ram_wen  (ram_wen),
        .ram_addr (ram_addr),
        .ram_store(ram_store),
        .ram_load (ram_load),
        .ram_state(ram_state),
        .bus_err  (bus_err),
        .err_clr  (err_clr)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int nhit;
        string seq;

        nRST      = 1'b0;
        iREN      = 1'b1;
        iaddr     = 32'h100;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        daddr     = '0;
        dstore    = '0;
        ram_load  = '0;
        ram_state = c_FREE;
        err_clr   = 1'b0;

        // Reset with iREN asserted: everything quiet.
        tick();
        tick();
        check("rst_ihit", {31'd0, ihit}, 32'd0);
        check("rst_dhit", {31'd0, dhit}, 32'd0);
        check("rst_ren", {31'd0, ram_ren}, 32'd0);
        check("rst_wen", {31'd0, ram_wen}, 32'd0);
        check("rst_addr", ram_addr, 32'd0);
        check("rst_err", {31'd0, bus_err}, 32'd0);
        check("rst_iload", iload, 32'd0);

        // Zero-wait instruction fetch: hit 2 cycles after accept.
        ram_state = c_ACCESS;
        ram_load  = 32'hCAFE0001;
        nRST      = 1'b1;
        tick();
        check("t1_ren", {31'd0, ram_ren}, 32'd1);
        check("t1_addr", ram_addr, 32'h100);
        check("t1_ihit_early", {31'd0, ihit}, 32'd0);
        tick();
        check("t1_ren_drop", {31'd0, ram_ren}, 32'd0);
        check("t1_ihit_wait", {31'd0, ihit}, 32'd0);
        tick();
        check("t1_ihit", {31'd0, ihit}, 32'd1);
        check("t1_iload", iload, 32'hCAFE0001);
        tick();
        check("t1_ihit_pulse", {31'd0, ihit}, 32'd0);
        check("t1_iload_clr", iload, 32'd0);
        check("t1_no_rearb", {31'd0, ram_ren}, 32'd0);
        iREN = 1'b0;
        tick();
        check("t1_no_double", {31'd0, ram_ren}, 32'd0);

        // Data read with 3 BUSY cycles.
        ram_state = c_BUSY;
        daddr     = 32'h40;
        dREN      = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ram_ren === 1'b1 && ram_addr === 32'h40) n++;
        end
        check("t2_ren_cycles", n, 32'd4);
        ram_state = c_ACCESS;
        ram_load  = 32'hDEADBEEF;
        tick();
        check("t2_ren_drop", {31'd0, ram_ren}, 32'd0);
        check("t2_dhit_wait", {31'd0, dhit}, 32'd0);
        tick();
        check("t2_dhit", {31'd0, dhit}, 32'd1);
        check("t2_dload", dload, 32'hDEADBEEF);
        tick();
        check("t2_dhit_pulse", {31'd0, dhit}, 32'd0);
        check("t2_dload_clr", dload, 32'd0);
        check("t2_no_rearb", {31'd0, ram_ren}, 32'd0);
        dREN      = 1'b0;
        ram_state = c_FREE;
        tick();
        check("t2_no_double", {31'd0, ram_ren}, 32'd0);

        // Write; dstore changes mid-wait must not reach the RAM.
        ram_state = c_BUSY;
        daddr     = 32'h80;
        dstore    = 32'h1234;
        dWEN      = 1'b1;
        tick();
        check("t3_wen", {31'd0, ram_wen}, 32'd1);
        check("t3_ren", {31'd0, ram_ren}, 32'd0);
        check("t3_addr", ram_addr, 32'h80);
        check("t3_store", ram_store, 32'h1234);
        dstore = 32'h5555;
        tick();
        check("t3_store_held", ram_store, 32'h1234);
        check("t3_wen_held", {31'd0, ram_wen}, 32'd1);
        ram_state = c_ACCESS;
        ram_load  = 32'hFFFFFFFF;
        tick();
        check("t3_wen_drop", {31'd0, ram_wen}, 32'd0);
        tick();
        check("t3_dhit", {31'd0, dhit}, 32'd1);
        check("t3_dload", dload, 32'd0);
        tick();
        check("t3_dhit_pulse", {31'd0, dhit}, 32'd0);
        dWEN      = 1'b0;
        ram_state = c_FREE;
        check("t3_err", {31'd0, bus_err}, 32'd0);

        // Timeout with TIMEOUT=8 and RAM stuck BUSY.
        ram_state = c_BUSY;
        ram_load  = 32'hABCD;
        daddr     = 32'h44;
        dREN      = 1'b1;
        tick();
        n = 0;
        while (ram_ren === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        check("t5_strobe_cycles", n, 32'd8);
        check("t5_err_set", {31'd0, bus_err}, 32'd1);
        tick();
        check("t5_dhit", {31'd0, dhit}, 32'd1);
        check("t5_dload", dload, 32'd0);
        tick();
        check("t5_dhit_pulse", {31'd0, dhit}, 32'd0);
        dREN = 1'b0;
        tick();
        check("t5_err_sticky", {31'd0, bus_err}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_err_clr", {31'd0, bus_err}, 32'd0);
        ram_state = c_FREE;

        // Reset during D_REQ, then a normal instruction fetch.
        ram_state = c_BUSY;
        daddr     = 32'h60;
        dREN      = 1'b1;
        tick();
        check("t6_ren", {31'd0, ram_ren}, 32'd1);
        tick();
        #1;
        nRST = 1'b0;
        #1;
        check("t6_async_ren", {31'd0, ram_ren}, 32'd0);
        check("t6_async_addr", ram_addr, 32'd0);
        dREN = 1'b0;
        tick();
        check("t6_no_dhit_rst", {31'd0, dhit}, 32'd0);
        nRST      = 1'b1;
        iREN      = 1'b1;
        iaddr     = 32'h700;
        ram_state = c_ACCESS;
        ram_load  = 32'h77;
        tick();
        check("t6_i_ren", {31'd0, ram_ren}, 32'd1);
        check("t6_i_addr", ram_addr, 32'h700);
        check("t6_no_dhit", {31'd0, dhit}, 32'd0);
        tick();
        tick();
        check("t6_ihit", {31'd0, ihit}, 32'd1);
        check("t6_iload", iload, 32'h77);
        check("t6_no_dhit2", {31'd0, dhit}, 32'd0);
        tick();
        iREN = 1'b0;
        tick();

        // Both ports held: alternating service, hits never coincide.
        iREN  = 1'b1;
        dREN  = 1'b1;
        iaddr = 32'h200;
        daddr = 32'h300;
        seq   = "";
        nhit  = 0;
        n     = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (ihit === 1'b1 && dhit === 1'b1) n++;
            if (dhit === 1'b1) begin
                seq = {seq, "D"};
                nhit++;
            end
            if (ihit === 1'b1) begin
                seq = {seq, "I"};
                nhit++;
            end
        end
        iREN = 1'b0;
        dREN = 1'b0;
        check("t4_coincide", n, 32'd0);
        check("t4_hits", nhit, 32'd4);
        tests++;
        assert (seq == "DIDI") else begin
            failed++;
            $error("FAIL t4_order: observed %s expected DIDI", seq);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
